// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states,
// opcode/funct fields and ALU operation codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_WB_R    = 4'd8,
        S_WB_I    = 4'd9,
        S_BR      = 4'd10,
        S_JMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    // True for the R-type funct codes the core implements.
    function automatic logic r_funct_ok(input logic [5:0] f);
        return (f == F_ADDU) || (f == F_SUBU) || (f == F_SLT);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation and immediate-extension select, derived from the current
// state and the instruction fields.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [1:0] alu_ctr,
    output logic       ext_op
);

    always_comb begin
        alu_ctr = ALU_ADD;
        ext_op  = 1'b1;
        case (state)
            S_EX_R: begin
                case (funct)
                    F_SUBU:  alu_ctr = ALU_SUB;
                    F_SLT:   alu_ctr = ALU_SLT;
                    default: alu_ctr = ALU_ADD;
                endcase
            end
            S_EX_I: begin
                // ori is a logical op, so its immediate is zero-extended
                if (op == OP_ORI) begin
                    alu_ctr = ALU_OR;
                    ext_op  = 1'b0;
                end
            end
            S_BR:    alu_ctr = ALU_SUB;
            default: alu_ctr = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback
// sequencing over a shared ALU and a single ready-handshaked memory port.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ST_W = 4,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    input  logic            upover,
    input  logic            mem_rdy,
    output logic            pc_wr,
    output logic            pc_wr_cond,
    output logic            i_or_d,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_wr,
    output logic            reg_wr,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_ctr,
    output logic            ext_op,
    output logic [1:0]      pc_src,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    state_t state_reg;
    state_t state_next;
    logic   ovf_reg;
    logic   id_ok;

    // The branch condition is applied in the datapath by gating pc_wr_cond
    // with zero, so the sequencer itself never branches on it.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_reg;

    always_comb begin
        id_ok = 1'b0;
        case (op)
            OP_RTYPE:               id_ok = r_funct_ok(funct);
            OP_ORI, OP_ADDI:        id_ok = 1'b1;
            OP_LW, OP_SW:           id_ok = 1'b1;
            OP_BEQ, OP_J:           id_ok = 1'b1;
            default:                id_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IF;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_EX_I)
                ovf_reg <= upover;
            else if (state_reg == S_IF)
                ovf_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = S_IF;
        case (state_reg)
            S_IF:      state_next = mem_rdy ? S_ID : S_IF;
            S_ID: begin
                if (!id_ok)
                    state_next = S_IF;
                else begin
                    case (op)
                        OP_RTYPE:      state_next = S_EX_R;
                        OP_ORI,
                        OP_ADDI:       state_next = S_EX_I;
                        OP_LW, OP_SW:  state_next = S_MEM_ADR;
                        OP_BEQ:        state_next = S_BR;
                        OP_J:          state_next = S_JMP;
                        default:       state_next = S_IF;
                    endcase
                end
            end
            S_EX_R:    state_next = S_WB_R;
            S_EX_I:    state_next = S_WB_I;
            S_MEM_ADR: state_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_next = mem_rdy ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:  state_next = mem_rdy ? S_IF : S_MEM_WR;
            default:   state_next = S_IF;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .state   (state_reg),
        .op      (op),
        .funct   (funct),
        .alu_ctr (alu_ctr),
        .ext_op  (ext_op)
    );

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        case (state_reg)
            S_IF: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = mem_rdy;
                pc_wr     = mem_rdy;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                illegal   = !id_ok;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
            end
            S_EX_I, S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_WB_I: begin
                // an overflowing addi must not commit its result
                reg_wr = !((op == OP_ADDI) && ovf_reg);
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                pc_src     = 2'b01;
                pc_wr_cond = 1'b1;
            end
            S_JMP: begin
                pc_wr  = 1'b1;
                pc_src = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
